// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and defaults for the shared shift-add multiplier controller.
// Widths derive from NREQ_DEF/W_DEF unless overridden per instance.
package mult_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 6;
  localparam int IDW      = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_e;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request/response bundle between requesters, consumer and the controller.
// The controller uses the slave modport; producers/consumer use master.
interface mult_share_ctrl_if
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
);

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              busy;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_data,
    output busy
  );

endinterface

// File: rtl/mult_share_ctrl_core.sv
// Sequential shift-add multiplier datapath: one partial product per step.
// product is the accumulator including the current step's addend.
module mult_core
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           count_done,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] addend;

  assign addend     = mplier_q[0] ? mcand_q : '0;
  assign product    = acc_q + addend;
  assign count_done = (count_q == CW'(W - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    unique case (1'b1)
      load: begin
        mcand_d  = {{W{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        count_d  = '0;
      end
      step: begin
        acc_d    = product;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier.
// Owns grant, rr pointer, the IDLE/RUN/RESP FSM and the response register.
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_share_ctrl_if.slave bus
);

  localparam int ID_W =
    (NREQ == NREQ_DEF) ? IDW : $clog2(NREQ);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [2*W-1:0]  rsp_data_q, rsp_data_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [ID_W:0]   srch;
  logic [ID_W-1:0] cand;
  logic [W-1:0]    op_a, op_b;
  logic            load, step;
  logic            count_done;
  logic [2*W-1:0]  product;

  // First valid index at or after rr_ptr, wrapping mod NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    srch      = '0;
    cand      = '0;
    op_a      = '0;
    op_b      = '0;
    for (int k = 0; k < NREQ; k++) begin
      srch = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (srch >= (ID_W+1)'(NREQ))
        srch = srch - (ID_W+1)'(NREQ);
      cand = srch[ID_W-1:0];
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found)
      gnt_oh[gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a = bus.req_a[i*W +: W];
        op_b = bus.req_b[i*W +: W];
      end
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign bus.req_ready =
    (rst_n && state_q == IDLE) ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    load        = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          load     = 1'b1;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1))
                   ? '0 : gnt_idx + 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count_done) begin
          rsp_data_d  = product;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  mult_core #(
    .W (W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .a          (op_a),
    .b          (op_b),
    .count_done (count_done),
    .product    (product)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 6;

  logic clk;
  logic rst_n;
  logic [NREQ-1:0]   valid;
  logic [NREQ-1:0]   auto_rq;
  logic              rsp_rdy;
  logic [W-1:0]      a_arr [NREQ];
  logic [W-1:0]      b_arr [NREQ];
  logic [NREQ*W-1:0] pa, pb;

  mult_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i*W +: W] = a_arr[i];
      pb[i*W +: W] = b_arr[i];
    end
  end

  assign bus.req_valid = valid;
  assign bus.req_a     = pa;
  assign bus.req_b     = pb;
  assign bus.rsp_ready = rsp_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int qget(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Logs of observed DUT events (negedge cycle numbers).
  int g_id[$], g_cyc[$], v_cyc[$], r_data[$], r_id[$];

  task automatic clr_logs();
    g_id.delete(); g_cyc.delete(); v_cyc.delete();
    r_data.delete(); r_id.delete();
  endtask

  // Model: a grant starts a product a*b that appears W cycles later
  // and is held until taken; requests rotate from the last grant.
  int              m_ptr, m_left, mg;
  bit              m_run, m_resp, prev_v;
  logic [2*W-1:0]  m_data, m_pdata;
  logic [1:0]      m_id, m_pid;
  logic [NREQ-1:0] mer, acc_mask;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_left = 0; m_run = 0; m_resp = 0;
      m_data = '0; m_id = '0; acc_mask = '0; prev_v = 0;
      chk("rst_outs", {bus.req_ready, bus.rsp_valid, bus.busy,
                       bus.rsp_id, bus.rsp_data}, 0);
    end else begin
      mg = -1;
      mer = '0;
      if (!m_run && !m_resp)
        for (int k = 0; k < NREQ; k++)
          if (mg < 0 && valid[(m_ptr + k) % NREQ])
            mg = (m_ptr + k) % NREQ;
      if (mg >= 0) mer[mg] = 1'b1;
      chk("req_ready", bus.req_ready, mer);
      chk("rsp_valid", bus.rsp_valid, m_resp);
      chk("busy", bus.busy, m_run || m_resp);
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_data", bus.rsp_data, m_data);
      acc_mask = bus.req_ready & valid;
      for (int i = 0; i < NREQ; i++)
        if (acc_mask[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      if (bus.rsp_valid && !prev_v) v_cyc.push_back(cyc);
      prev_v = bus.rsp_valid;
      if (bus.rsp_valid && rsp_rdy) begin
        r_data.push_back(int'(bus.rsp_data));
        r_id.push_back(int'(bus.rsp_id));
      end
      if (m_resp) begin
        if (rsp_rdy) m_resp = 0;
      end else if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0; m_resp = 1;
          m_data = m_pdata; m_id = m_pid;
        end
      end else if (mg >= 0) begin
        m_pdata = (2*W)'(a_arr[mg]) * (2*W)'(b_arr[mg]);
        m_pid = 2'(mg);
        m_left = W;
        m_run = 1;
        m_ptr = (mg + 1) % NREQ;
      end
    end
  end

  task automatic rnd_op(int i);
    a_arr[i] = W'($urandom_range(0, (1 << W) - 1));
    b_arr[i] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Advance one cycle; accepted requests drop or re-arm.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[i]) begin
        if (auto_rq[i]) rnd_op(i);
        else valid[i] = 1'b0;
      end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int lat;
  int ea [4] = '{5, 17, 40, 63};
  int eb [4] = '{9, 33, 2, 61};
  int ep [4] = '{45, 561, 80, 3843};

  initial begin
    rst_n = 1'b0; valid = '0; auto_rq = '0; rsp_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0; b_arr[i] = '0;
    end
    #12;
    chk("rst_init", {bus.req_ready, bus.rsp_valid, bus.busy,
                     bus.rsp_id, bus.rsp_data}, 0);
    #4;
    rst_n = 1'b1;

    // Single request, max operands.
    clr_logs();
    rsp_rdy = 1'b1;
    a_arr[2] = 6'd63; b_arr[2] = 6'd63;
    valid = 4'b0100;
    repeat (14) step();
    chk("t1_ngrant", g_id.size(), 1);
    chk("t1_gid", qget(g_id, 0), 2);
    lat = qget(v_cyc, 0) - qget(g_cyc, 0) - 1;
    chk("t1_lat", lat, W);
    chk("t1_data", qget(r_data, 0), 3969);
    chk("t1_id", qget(r_id, 0), 2);

    // Four simultaneous requests from reset pointer.
    do_reset();
    clr_logs();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = W'(ea[i]); b_arr[i] = W'(eb[i]);
    end
    valid = 4'b1111;
    repeat (40) step();
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", qget(g_id, k), k);
      chk("t2_data", qget(r_data, k), ep[k]);
      chk("t2_id", qget(r_id, k), k);
    end
    for (int k = 1; k < 4; k++)
      chk("t2_space", qget(g_cyc, k) - qget(g_cyc, k-1), W + 2);

    // Fairness between two persistent requesters.
    clr_logs();
    rnd_op(0); rnd_op(3);
    auto_rq = 4'b1001;
    valid = 4'b1001;
    repeat (20 * (W + 2) + 4) step();
    auto_rq = '0;
    valid = '0;
    repeat (10) step();
    chk("t3_cnt", g_id.size() >= 20, 1);
    for (int k = 0; k < 20; k++)
      chk("t3_alt", qget(g_id, k), (k % 2) ? 3 : 0);

    // Backpressure with a competing requester waiting.
    rsp_rdy = 1'b0;
    a_arr[1] = 6'd7; b_arr[1] = 6'd9;
    a_arr[2] = 6'd3; b_arr[2] = 6'd5;
    valid = 4'b0110;
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) step();
    chk("t4_wait", bus.rsp_valid, 1);
    repeat (10) begin
      step();
      chk("t4_hold", {bus.rsp_valid, bus.busy, bus.req_ready,
                      bus.rsp_id, bus.rsp_data},
          {1'b1, 1'b1, 4'b0000, 2'd1, 12'd63});
    end
    rsp_rdy = 1'b1;
    step();
    chk("t4_rel", {bus.rsp_valid, bus.busy, bus.req_ready},
        {1'b0, 1'b0, 4'b0100});
    repeat (12) step();

    // Edge operands still take the full sequence.
    for (int c = 0; c < 2; c++) begin
      clr_logs();
      a_arr[0] = W'(c); b_arr[0] = (c == 0) ? 6'd63 : 6'd1;
      valid = 4'b0001;
      repeat (12) step();
      chk("t5_data", qget(r_data, 0), c);
      lat = qget(v_cyc, 0) - qget(g_cyc, 0) - 1;
      chk("t5_lat", lat, W);
    end

    // Reset in the third RUN cycle discards the product.
    clr_logs();
    rnd_op(2);
    valid = 4'b0100;
    for (int k = 0; k < 10 && g_id.size() == 0; k++) step();
    chk("t6_acc", g_id.size(), 1);
    step(); step();
    #2;
    rst_n = 1'b0;
    valid = '0;
    #1;
    chk("t6_async", {bus.req_ready, bus.rsp_valid, bus.busy,
                     bus.rsp_id, bus.rsp_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_logs();
    repeat (12) step();
    chk("t6_norsp", v_cyc.size(), 0);
    rnd_op(1); rnd_op(3);
    valid = 4'b1010;
    repeat (3) step();
    chk("t6_ptr", qget(g_id, 0), 1);
    repeat (20) step();

    // Random traffic, withdrawals and backpressure.
    for (int n = 0; n < 1500; n++) begin
      step();
      rsp_rdy = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!valid[i] && $urandom_range(0, 3) == 0) begin
          rnd_op(i);
          valid[i] = 1'b1;
        end else if (valid[i] && $urandom_range(0, 15) == 0)
          valid[i] = 1'b0;
      end
    end
    valid = '0;
    rsp_rdy = 1'b1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing controller and round-robin arbiter that shares one sequential shift-add multiplier datapath among several requesters. Each requester presents unsigned operands through a valid/ready handshake. The controller grants one requester at a time and runs the W-iteration shift-add sequence. It returns the 2W-bit product, tagged with the requester index, on a single response channel with backpressure. It sits between the operand-producing blocks and the shared multiplier and owns that multiplier's start, step and completion sequencing.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 6, operand width in bits; product is 2W bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*W  packed multiplicands, requester i at [i*W +: W]
- req_b  in  NREQ*W  packed multipliers, same packing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_data
- rsp_data  out  2W  unsigned product a*b
- busy  out  1  high in RUN and RESP

## Operation
- FSM states are IDLE, RUN and RESP.
- Reset values: state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, req_ready 0.
- IDLE, grant rule:
  - req_ready is combinational.
  - It is high only for the first index g, searched from rr_ptr upward and wrapping mod NREQ, with req_valid[g]=1.
  - All other bits are 0.
- IDLE, accept (req_valid[g] & req_ready[g]):
  - Load multiplicand = zero-extended req_a[g] to 2W bits, multiplier = req_b[g], acc = 0, count = 0, id = g.
  - Set rr_ptr = (g+1) mod NREQ and go to RUN.
- RUN, each cycle:
  - If multiplier[0], acc += multiplicand (2W-bit add, cannot overflow).
  - multiplicand <<= 1, multiplier >>= 1, count++.
  - When count reaches W-1 (the W-th iteration), register rsp_data = the final acc value, rsp_id = id and rsp_valid = 1, then go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On handshake: rsp_valid = 0, go to IDLE. rsp_data and rsp_id keep their last value.
- Requester obligations:
  - Hold req_valid, req_a and req_b stable until accepted.
  - Operands are sampled only on the accept edge, so later changes have no effect.
- Zero operands still take the full W iterations. There is no early termination.

## Timing
- Accept on edge t. rsp_valid is first high in the cycle after edge t+W, which is W cycles after accept.
- With rsp_ready held at 1, the response handshake takes 1 cycle. Next grant is possible no earlier than the following cycle.
- Peak throughput is one product per W+2 cycles.
- No accept occurs in RUN or RESP; req_ready is all zero there.
- Simultaneous requests: exactly one is granted per IDLE cycle. Priority rotates, so every continuously requesting index is served within NREQ grants.
- A requester that deasserts req_valid before accept loses the grant with no side effect.
- rsp_ready asserted while rsp_valid=0 is ignored.
- An rst_n assertion mid-RUN or mid-RESP aborts immediately:
  - all registers go to reset values;
  - the in-flight product is discarded;
  - no response is produced after release.

## Structure
- Shared package mult_pkg holds:
  - the default W and NREQ;
  - the IDW = clog2(NREQ) localparam;
  - the state enum {IDLE, RUN, RESP}.
- Sub-module mult_core: shift-add datapath with load (operands) and step inputs, and count_done and product outputs.
- The arbiter, rr_ptr, FSM and response register stay in mult_share_ctrl.

## Test plan
- Single request: requester 2 only, a=63, b=63. Expect one accept, rsp_valid 6 cycles later, rsp_data=3969 (0xF81), rsp_id=2.
- All four request at reset (rr_ptr=0) with distinct operands, rsp_ready=1. Expect grants in order 0,1,2,3, each spaced 8 cycles, with correct products and ids.
- Fairness: requesters 0 and 3 always valid. Expect grants alternating 0,3,0,3 and no starvation over 20 products.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Expect rsp_data and rsp_id stable, req_ready all 0, busy=1. Then rsp_ready=1 gives handshake and a return to IDLE.
- Edge operands: a=0, b=63 gives 0; a=1, b=1 gives 1. Both take the full 6 RUN cycles.
- Reset mid-RUN: assert rst_n=0 at cycle 3 of RUN. Expect all outputs 0 asynchronously, and after release no rsp_valid and rr_ptr=0.
